// File: rtl/uart_rx_9600.sv
// 8N1 UART receiver: two-flop input sync, mid-bit sampling, valid/ack holding register.
// Define UART_RX_PARITY_EN to receive 8E1 frames and flag even-parity mismatches.
module uart_rx_9600 #(
  parameter int CLKS_PER_BIT = 521,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       osc_clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  output logic       rx_parity_err,
  output logic       rx_busy
);
  localparam logic [9:0] LP_HALF = 10'(HALF_BIT);
  localparam logic [9:0] LP_LAST = 10'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic       r_rxd_meta;
  logic       r_rxd_s;
  logic [9:0] r_cnt;
  logic [9:0] w_cnt_next;
  logic [2:0] r_bit_idx;
  logic [2:0] w_bit_idx_next;
  logic [7:0] r_shift;
  logic [7:0] w_shift_next;
  logic [7:0] r_data;
  logic       r_valid;
  logic       r_overrun;
  logic       r_frame_err;
  logic       w_deliver;
  logic       w_frame_err;
  logic       w_ack;
`ifdef UART_RX_PARITY_EN
  logic       r_par_bad;
  logic       w_par_bad_next;
  logic       r_parity_err;
`endif

  assign w_ack = rx_ack & r_valid;

  // Counter free-runs within a state; every sample point and state entry restarts it.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt + 10'd1;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_deliver      = 1'b0;
    w_frame_err    = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bad_next = r_par_bad;
`endif
    case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        if (!r_rxd_s) w_state_next = S_START;
      end
      S_START: begin
        if (r_cnt == LP_HALF) begin
          w_cnt_next     = '0;
          w_bit_idx_next = '0;
          w_state_next   = r_rxd_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == LP_LAST) begin
          w_cnt_next              = '0;
          w_shift_next[r_bit_idx] = r_rxd_s;
          w_bit_idx_next          = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_next = S_PARITY;
`else
            w_state_next = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (r_cnt == LP_LAST) begin
          w_cnt_next     = '0;
          w_par_bad_next = (^r_shift) ^ r_rxd_s;
          w_state_next   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (r_cnt == LP_LAST) begin
          w_cnt_next = '0;
          if (r_rxd_s) begin
            w_deliver    = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_frame_err  = 1'b1;
            w_state_next = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        // A held-low (break) line must return high before a new start edge counts.
        w_cnt_next = '0;
        if (r_rxd_s) w_state_next = S_IDLE;
      end
      default: begin
        w_cnt_next   = '0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge osc_clk) begin
    if (rst) begin
      r_rxd_meta  <= 1'b1;
      r_rxd_s     <= 1'b1;
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rxd_meta  <= rxd;
      r_rxd_s     <= r_rxd_meta;
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_bit_idx   <= w_bit_idx_next;
      r_shift     <= w_shift_next;
      r_frame_err <= w_frame_err;
      if (w_ack) begin
        r_valid   <= 1'b0;
        r_overrun <= 1'b0;
      end
      // An ack in the completion cycle consumes the old byte, so no overrun.
      if (w_deliver) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
        if (r_valid && !rx_ack) r_overrun <= 1'b1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge osc_clk) begin
    if (rst) begin
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_par_bad <= w_par_bad_next;
      if (w_deliver) r_parity_err <= (r_parity_err & ~w_ack) | r_par_bad;
      else if (w_ack) r_parity_err <= 1'b0;
    end
  end
  assign rx_parity_err = r_parity_err;
`else
  assign rx_parity_err = 1'b0;
`endif

  assign rx_data      = r_data;
  assign rx_valid     = r_valid;
  assign rx_overrun   = r_overrun;
  assign rx_frame_err = r_frame_err;
  assign rx_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_9600.sv
// Bench for uart_rx_9600: a frame-timeline reference model checked every cycle,
// plus directed frames with hand-computed expectations.
`timescale 1ns/1ps
module tb_uart_rx_9600;
  localparam int C    = 521;
  localparam int HALF = 260;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 9;
  localparam int LAT   = 5474;
`else
  localparam int NBITS = 8;
  localparam int LAT   = 4953;
`endif
  localparam int STOP_AT = HALF + (NBITS + 1) * C;

  logic       osc_clk = 1'b0;
  logic       rst     = 1'b1;
  logic       rxd     = 1'b1;
  logic       rx_ack  = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_overrun;
  logic       rx_frame_err;
  logic       rx_parity_err;
  logic       rx_busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;
  int last_start_cyc = 0;
  int valid_rise_cyc = 0;
  int busy_cnt = 0;
  int ferr_cnt = 0;
  logic prev_valid = 1'b0;

  // reference model state
  int         m_mode = 0;
  int         m_r = 0;
  int         m_k = 0;
  logic       m_ln;
  logic       m_p1 = 1'b1;
  logic       m_p2 = 1'b1;
  logic [7:0] m_shift = '0;
  logic       m_deliver;
  logic       m_ackeff;
  logic       m_vold;
`ifdef UART_RX_PARITY_EN
  logic       m_pbad = 1'b0;
`endif
  logic [7:0] e_data = '0;
  logic       e_valid = 1'b0;
  logic       e_ovr = 1'b0;
  logic       e_ferr = 1'b0;
  logic       e_perr = 1'b0;
  logic       e_busy = 1'b0;
  logic [12:0] act_v;
  logic [12:0] exp_v;

  uart_rx_9600 dut (
    .osc_clk      (osc_clk),
    .rst          (rst),
    .rxd          (rxd),
    .rx_ack       (rx_ack),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err),
    .rx_parity_err(rx_parity_err),
    .rx_busy      (rx_busy)
  );

  always #100 osc_clk = ~osc_clk;

  // Model: the receiver sees the pin two clocks late; a frame is a timeline of
  // sample points measured from the first busy cycle.
  initial begin
    forever begin
      @(posedge osc_clk);
      cyc++;
      m_ln = m_p2;
      m_p2 = m_p1;
      m_p1 = rxd;
      if (rst) begin
        m_mode = 0; m_r = 0; m_shift = '0; m_p1 = 1'b1; m_p2 = 1'b1;
        e_data = '0; e_valid = 1'b0; e_ovr = 1'b0; e_ferr = 1'b0; e_perr = 1'b0;
`ifdef UART_RX_PARITY_EN
        m_pbad = 1'b0;
`endif
      end else begin
        m_deliver = 1'b0;
        e_ferr = 1'b0;
        if (m_mode == 0) begin
          if (!m_ln) begin m_mode = 1; m_r = 0; end
        end else if (m_mode == 1) begin
          if (m_r == HALF && m_ln) begin
            m_mode = 0;
          end else if (m_r == STOP_AT) begin
            if (m_ln) begin m_deliver = 1'b1; m_mode = 0; end
            else begin e_ferr = 1'b1; m_mode = 2; end
          end else begin
            if (m_r > HALF && ((m_r - HALF) % C) == 0) begin
              m_k = (m_r - HALF) / C - 1;
              if (m_k < 8) m_shift[m_k] = m_ln;
`ifdef UART_RX_PARITY_EN
              else m_pbad = (^m_shift) ^ m_ln;
`endif
            end
            m_r++;
          end
        end else begin
          if (m_ln) m_mode = 0;
        end
        m_vold = e_valid;
        m_ackeff = rx_ack && m_vold;
        if (m_ackeff) begin e_valid = 1'b0; e_ovr = 1'b0; e_perr = 1'b0; end
        if (m_deliver) begin
          if (m_vold && !m_ackeff) e_ovr = 1'b1;
          e_data = m_shift;
          e_valid = 1'b1;
`ifdef UART_RX_PARITY_EN
          e_perr = e_perr | m_pbad;
`endif
        end
      end
      e_busy = (m_mode != 0);
    end
  end

  // Per-cycle comparison against the model, plus observers for directed checks.
  initial begin
    forever begin
      @(negedge osc_clk);
      if (chk_en) begin
        act_v = {rx_data, rx_valid, rx_overrun, rx_frame_err, rx_parity_err, rx_busy};
        exp_v = {e_data, e_valid, e_ovr, e_ferr, e_perr, e_busy};
        tests++;
        if (act_v !== exp_v) begin
          fails++;
          $display("FAIL cycle_compare cyc=%0d got=%h expected=%h (data,valid,ovr,ferr,perr,busy)",
                   cyc, act_v, exp_v);
        end
        if (rx_valid && !prev_valid) valid_rise_cyc = cyc;
        prev_valid = rx_valid;
        if (rx_busy) busy_cnt++;
        if (rx_frame_err) ferr_cnt++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge osc_clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0h", name, act);
    end
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    tick(C);
  endtask

  // ack_in_stop raises rx_ack for exactly the cycle in which the byte completes.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop_b,
                            input bit ack_in_stop);
    $display("[TB] frame data=%h par=%b stop=%b ack_in_stop=%0d", d, par, stop_b, ack_in_stop);
    last_start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`endif
    rxd = stop_b;
    if (ack_in_stop) begin
      tick(HALF + 3);
      ack_pulse();
      tick(C - HALF - 4);
    end else begin
      tick(C);
    end
  endtask

  initial begin
    tick(4);
    check("reset_outputs", 32'({rx_data, rx_valid, rx_overrun, rx_frame_err, rx_parity_err, rx_busy}), 32'h0);
    chk_en = 1'b1;
    rst = 1'b0;
    tick(20);

    send_frame(8'h55, 1'b0, 1'b1, 0);
    check("t1_data", 32'(rx_data), 32'h55);
    check("model_data_55", 32'(e_data), 32'h55);
    check("t1_valid", 32'(rx_valid), 32'h1);
    check("t1_flags", 32'({rx_overrun, rx_frame_err, rx_parity_err}), 32'h0);
    check("t1_valid_latency", 32'(valid_rise_cyc - last_start_cyc), 32'(LAT));
    tick(5);
    ack_pulse();
    check("t1_ack_clears_valid", 32'(rx_valid), 32'h0);

    busy_cnt = 0;
    rxd = 1'b0;
    tick(100);
    rxd = 1'b1;
    tick(400);
    check("t2_glitch_busy_cycles", 32'(busy_cnt), 32'd261);
    check("t2_glitch_valid", 32'(rx_valid), 32'h0);
    check("t2_glitch_idle", 32'(rx_busy), 32'h0);

    ferr_cnt = 0;
    send_frame(8'hA3, 1'b0, 1'b0, 0);
    tick(3 * C);
    check("t3_wait_high_busy", 32'(rx_busy), 32'h1);
    rxd = 1'b1;
    tick(10);
    check("t3_frame_err_pulses", 32'(ferr_cnt), 32'd1);
    check("t3_idle_after_high", 32'(rx_busy), 32'h0);
    check("t3_valid", 32'(rx_valid), 32'h0);
    send_frame(8'h3C, 1'b0, 1'b1, 0);
    check("t3_next_data", 32'(rx_data), 32'h3C);
    check("t3_next_valid", 32'(rx_valid), 32'h1);
    check("t3_no_new_frame_err", 32'(ferr_cnt), 32'd1);
    ack_pulse();

    send_frame(8'h12, 1'b0, 1'b1, 0);
    send_frame(8'h34, 1'b1, 1'b1, 0);
    check("t4_data", 32'(rx_data), 32'h34);
    check("t4_valid", 32'(rx_valid), 32'h1);
    check("t4_overrun", 32'(rx_overrun), 32'h1);
    check("model_overrun", 32'(e_ovr), 32'h1);
    ack_pulse();
    check("t4_ack_clears", 32'({rx_valid, rx_overrun}), 32'h0);

    send_frame(8'h12, 1'b0, 1'b1, 0);
    send_frame(8'h34, 1'b1, 1'b1, 1);
    check("t4b_data", 32'(rx_data), 32'h34);
    check("t4b_valid", 32'(rx_valid), 32'h1);
    check("t4b_no_overrun", 32'(rx_overrun), 32'h0);

    rxd = 1'b0;
    tick(C);
    rxd = 1'b1;
    tick(4 * C + C / 2);
    rst = 1'b1;
    tick(1);
    check("t5_reset_outputs", 32'({rx_data, rx_valid, rx_overrun, rx_frame_err, rx_parity_err, rx_busy}), 32'h0);
    rst = 1'b0;
    tick(6 * C);
    check("t5_still_idle", 32'({rx_valid, rx_busy}), 32'h0);
    send_frame(8'h81, 1'b0, 1'b1, 0);
    check("t5_data", 32'(rx_data), 32'h81);
    check("t5_valid", 32'(rx_valid), 32'h1);
    check("t5_overrun", 32'(rx_overrun), 32'h0);
    ack_pulse();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 0);
    check("t6_good_parity_valid", 32'(rx_valid), 32'h1);
    check("t6_good_parity_err", 32'(rx_parity_err), 32'h0);
    ack_pulse();
    send_frame(8'h07, 1'b0, 1'b1, 0);
    check("t6_bad_parity_data", 32'(rx_data), 32'h07);
    check("t6_bad_parity_valid", 32'(rx_valid), 32'h1);
    check("t6_bad_parity_err", 32'(rx_parity_err), 32'h1);
    ack_pulse();
    check("t6_ack_clears", 32'({rx_valid, rx_parity_err}), 32'h0);
`endif

    tick(10);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
